// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 fetch types, reset PC default, NOP encoding and PC alignment helper
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
   typedef logic [XLEN-1:0] word_t;
   typedef struct packed {
      word_t pc;
      word_t data;
   } inst_t;
   function automatic word_t align_pc(input word_t pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/if_slot_buffer.sv
// if_slot_buffer: circular alloc/fill/pop buffer of fetched {pc, instr} with single-cycle flush
module if_slot_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   input  logic          i_alloc,
   input  word_t         i_alloc_pc,
   input  logic          i_fill,
   input  word_t         i_fill_data,
   input  logic          i_pop,
   output logic          o_head_valid,
   output inst_t         o_head,
   output logic [PW-1:0] o_used,
   output logic [PW-1:0] o_unfilled
);
   logic [PW-1:0] r_alloc_ptr, r_fill_ptr, r_head_ptr;
   word_t         r_pc   [DEPTH];
   word_t         r_data [DEPTH];
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
      end else begin
         if (i_alloc) r_alloc_ptr <= r_alloc_ptr + PW'(1);
         if (i_fill)  r_fill_ptr  <= r_fill_ptr + PW'(1);
         if (i_pop)   r_head_ptr  <= r_head_ptr + PW'(1);
      end
   end
   // payload storage needs no reset; validity lives entirely in the pointers
   always_ff @(posedge clk) begin
      if (i_alloc) r_pc[r_alloc_ptr[AW-1:0]] <= i_alloc_pc;
      if (i_fill)  r_data[r_fill_ptr[AW-1:0]] <= i_fill_data;
   end
   assign o_used       = r_alloc_ptr - r_head_ptr;
   assign o_unfilled   = r_alloc_ptr - r_fill_ptr;
   assign o_head_valid = r_fill_ptr != r_head_ptr;
   assign o_head       = '{pc: r_pc[r_head_ptr[AW-1:0]], data: r_data[r_head_ptr[AW-1:0]]};
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, in-order imem requests, redirect flush and stale-response killing
module if_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_data
);
   localparam int PW = $clog2(DEPTH) + 1;
   word_t         r_fetch_pc;
   logic [PW-1:0] r_kill_cnt;
   logic          w_req_fire, w_fill, w_pop, w_head_valid;
   inst_t         w_head;
   logic [PW-1:0] w_used, w_unfilled;
   assign imem_req_valid = !rst && !redirect_valid && (w_used < PW'(DEPTH));
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_fill         = imem_rsp_valid && !redirect_valid && (r_kill_cnt == '0);
   assign w_pop          = inst_valid && inst_ready && !redirect_valid;
   assign inst_valid     = !rst && w_head_valid;
   assign inst_pc        = w_head.pc;
   assign inst_data      = w_head.data;
   // on redirect every unfilled slot becomes a response to throw away; the one arriving now is dropped too
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_kill_cnt <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= align_pc(redirect_pc);
         r_kill_cnt <= r_kill_cnt + w_unfilled - PW'(imem_rsp_valid);
      end else begin
         if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
         if (imem_rsp_valid && r_kill_cnt != '0) r_kill_cnt <= r_kill_cnt - PW'(1);
      end
   end
   if_slot_buffer #(.DEPTH(DEPTH)) u_slots (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (redirect_valid),
      .i_alloc      (w_req_fire),
      .i_alloc_pc   (r_fetch_pc),
      .i_fill       (w_fill),
      .i_fill_data  (imem_rsp_data),
      .i_pop        (w_pop),
      .o_head_valid (w_head_valid),
      .o_head       (w_head),
      .o_used       (w_used),
      .o_unfilled   (w_unfilled)
   );
   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (r_kill_cnt != '0 || w_unfilled != '0));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of reset, streaming, backpressure, redirects and PC wrap
module tb_if_fetch_unit;
   typedef struct {
      logic [31:0] a;
      int          due;
   } mem_ent_t;
   logic        clk = 0;
   logic        rst = 1;
   logic        redirect_valid = 0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 0;
   logic [31:0] inst_pc, inst_data;
   int          checks = 0, failures = 0;
   int          cyc = 0, lat = 1, outst = 0, max_out = 0;
   mem_ent_t    mq[$];
   mem_ent_t    ent;
   logic [63:0] dq[$];
   logic [31:0] exp_pc, st_pc, st_data;
   always #5 clk = ~clk;
   if_fetch_unit #(.RESET_PC(32'h100), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data)
   );
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h1357_9BDF;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // in-order memory with per-request latency `lat`, plus a recorder of accepted instructions
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         outst = 0;
         imem_rsp_valid <= 0;
      end else begin
         if (imem_rsp_valid) outst--;
         if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{a: imem_req_addr, due: cyc + lat - 1});
            outst++;
         end
         if (outst > max_out) max_out = outst;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            ent = mq.pop_front();
            imem_rsp_valid <= 1;
            imem_rsp_data  <= mem_f(ent.a);
         end else imem_rsp_valid <= 0;
         if (inst_valid && inst_ready && !redirect_valid) dq.push_back({inst_pc, inst_data});
      end
      cyc++;
   end
   task automatic expect_next(input logic [31:0] pc);
      logic [63:0] e;
      int n = 0;
      while (dq.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (dq.size() == 0) check("deliver_timeout", 32'd0, 32'd1);
      else begin
         e = dq.pop_front();
         check("inst_pc", e[63:32], pc);
         check("inst_data", e[31:0], mem_f(pc));
      end
   endtask
   task automatic do_redirect(input logic [31:0] tgt);
      @(negedge clk);
      redirect_valid = 1;
      redirect_pc    = tgt;
      dq.delete();
      #1 check("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
      @(negedge clk);
      redirect_valid = 0;
      #1;
      check("redir_ivalid", {31'd0, inst_valid}, 32'd0);
      check("redir_reqv", {31'd0, imem_req_valid}, 32'd1);
      check("redir_addr", imem_req_addr, {tgt[31:2], 2'b00});
   endtask
   initial begin
      int n;
      repeat (2) begin
         @(negedge clk);
         check("rst_ivalid", {31'd0, inst_valid}, 32'd0);
         check("rst_reqv", {31'd0, imem_req_valid}, 32'd0);
      end
      rst = 0;
      #1;
      check("first_reqv", {31'd0, imem_req_valid}, 32'd1);
      check("first_addr", imem_req_addr, 32'h100);
      inst_ready = 1;
      exp_pc = 32'h100;
      for (int i = 0; i < 6; i++) begin
         expect_next(exp_pc);
         exp_pc += 4;
      end
      @(negedge clk);
      inst_ready = 0;
      repeat (3) @(negedge clk);
      max_out = 0;
      st_pc   = inst_pc;
      st_data = inst_data;
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_pc", st_pc, exp_pc + 32'(4 * dq.size()));
      check("stall_data", st_data, mem_f(st_pc));
      repeat (5) begin
         @(negedge clk);
         check("hold_pc", inst_pc, st_pc);
         check("hold_data", inst_data, st_data);
      end
      check("max_outstanding", {31'd0, max_out <= 2}, 32'd1);
      inst_ready = 1;
      for (int i = 0; i < 5; i++) begin
         expect_next(exp_pc);
         exp_pc += 4;
      end
      @(negedge clk);
      lat = 3;
      do_redirect(32'h1000);
      n = 0;
      while (imem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("pending_two", 32'(outst), 32'd2);
      do_redirect(32'h2002);
      for (int i = 0; i < 4; i++) expect_next(32'h2000 + 32'(4 * i));
      @(negedge clk);
      lat = 1;
      n = 0;
      while (!(inst_valid && imem_rsp_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("coincide", {31'd0, inst_valid && imem_rsp_valid}, 32'd1);
      redirect_valid = 1;
      redirect_pc    = 32'h3000;
      dq.delete();
      @(negedge clk);
      redirect_valid = 0;
      #1;
      check("coinc_ivalid", {31'd0, inst_valid}, 32'd0);
      check("coinc_addr", imem_req_addr, 32'h3000);
      for (int i = 0; i < 3; i++) expect_next(32'h3000 + 32'(4 * i));
      do_redirect(32'hFFFF_FFF8);
      expect_next(32'hFFFF_FFF8);
      expect_next(32'hFFFF_FFFC);
      expect_next(32'h0000_0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
